// File: rtl/serial_shift_tx_if.sv
// Handshake and serial-output bundle for serial_shift_tx.
// master = word source / serial consumer side, slave = the transmitter.
interface serial_shift_tx_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] din;
   logic             msb_first;
   logic             in_valid;
   logic             in_ready;
   logic             serial_out;
   logic             shift_en;
   logic             par_valid;
   logic             busy;
   logic             done;

   modport master (
      output din, msb_first, in_valid,
      input  in_ready, serial_out, shift_en, par_valid, busy, done
   );

   modport slave (
      input  din, msb_first, in_valid,
      output in_ready, serial_out, shift_en, par_valid, busy, done
   );
endinterface

// File: rtl/serial_shift_tx.sv
// Parallel-to-serial transmitter with shift_en strobe, LSB- or MSB-first.
// Define SERIAL_TX_PARITY_EN to append one even-parity bit per frame.
module serial_shift_tx #(
   parameter int WIDTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   serial_shift_tx_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SERIAL_TX_PARITY_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_PARITY = 2'd2} state_t;
`else
   typedef enum logic {S_IDLE = 1'b0, S_DATA = 1'b1} state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic             ord_q, ord_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             last_bit;
   logic             accept;
`ifdef SERIAL_TX_PARITY_EN
   logic             par_q, par_d;
`endif

   // Final-bit cycle: the slot in which a new word may be taken for a gapless follow-on frame.
`ifdef SERIAL_TX_PARITY_EN
   assign last_bit = (state_q == S_PARITY);
`else
   assign last_bit = (state_q == S_DATA) && (cnt_q == '0);
`endif
   assign accept = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sr_q    <= '0;
         ord_q   <= 1'b0;
         cnt_q   <= '0;
`ifdef SERIAL_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         ord_q   <= ord_d;
         cnt_q   <= cnt_d;
`ifdef SERIAL_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      ord_d   = ord_q;
      cnt_d   = cnt_q;
`ifdef SERIAL_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         S_IDLE: if (accept) state_d = S_DATA;
         S_DATA: begin
            if (cnt_q == '0) begin
`ifdef SERIAL_TX_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = accept ? S_DATA : S_IDLE;
`endif
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         S_PARITY: state_d = accept ? S_DATA : S_IDLE;
`endif
         default: state_d = S_IDLE;
      endcase

      // The register always moves toward whichever end feeds serial_out.
      if (accept) begin
         sr_d  = bus.din;
         ord_d = bus.msb_first;
         cnt_d = CW'(WIDTH - 1);
`ifdef SERIAL_TX_PARITY_EN
         par_d = ^bus.din;
`endif
      end else if (state_q == S_DATA) begin
         sr_d = ord_q ? (sr_q << 1) : (sr_q >> 1);
         if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
   end

   always_comb begin
      bus.in_ready   = (state_q == S_IDLE) || last_bit;
      bus.busy       = (state_q != S_IDLE);
      bus.done       = last_bit;
      bus.serial_out = 1'b0;
      bus.shift_en   = 1'b0;
      bus.par_valid  = 1'b0;
      case (state_q)
         S_DATA: begin
            bus.shift_en   = 1'b1;
            bus.serial_out = ord_q ? sr_q[WIDTH-1] : sr_q[0];
         end
`ifdef SERIAL_TX_PARITY_EN
         S_PARITY: begin
            bus.par_valid  = 1'b1;
            bus.serial_out = par_q;
         end
`endif
         default: ;
      endcase
   end
endmodule

// File: tb/tb_serial_shift_tx.sv
// Bench for serial_shift_tx: table of words plus back-to-back, busy-ignore and reset cases.
// Expected bits are queued on accept and popped each cycle the DUT is busy.
module tb_serial_shift_tx;
   localparam int W = 4;
`ifdef SERIAL_TX_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   serial_shift_tx_if #(.WIDTH(W)) bus ();

   serial_shift_tx #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         b;
      logic         par;
      logic         last;
      logic         chk;
      logic         ord;
      logic [W-1:0] rx;
   } item_t;

   typedef struct {
      logic [W-1:0] din;
      logic         msb;
      logic [W-1:0] seq;   // seq[i] = i-th transmitted data bit
      logic [W-1:0] rx;    // word a matching receiver should hold
   } vec_t;

   item_t        q[$];
   vec_t         vecs[6];
   int           n_chk = 0;
   int           n_fail = 0;
   int           run = 0;
   int           max_run = 0;
   int           n_done = 0;
   logic [W-1:0] rx_m = '0;
   logic [W-1:0] pend_seq = '0;
   logic [W-1:0] pend_rx = '0;
   logic         accepted = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push_frame();
      for (int i = 0; i < W; i++) begin
         item_t it;
         it.b   = pend_seq[i];
         it.par = 1'b0;
         it.ord = bus.msb_first;
         it.chk = (i == W - 1);
         it.rx  = pend_rx;
`ifdef SERIAL_TX_PARITY_EN
         it.last = 1'b0;
`else
         it.last = (i == W - 1);
`endif
         q.push_back(it);
      end
`ifdef SERIAL_TX_PARITY_EN
      begin
         item_t p;
         p.b = ^bus.din; p.par = 1'b1; p.last = 1'b1; p.chk = 1'b0; p.ord = 1'b0; p.rx = '0;
         q.push_back(p);
      end
`endif
   endtask

   task automatic monitor();
      if (bus.busy) run++; else run = 0;
      if (run > max_run) max_run = run;
      if (bus.done) n_done++;
      if (q.size() == 0) begin
         chk("idle_shift_en", bus.shift_en, 0);
         chk("idle_par_valid", bus.par_valid, 0);
         chk("idle_busy", bus.busy, 0);
         chk("idle_in_ready", bus.in_ready, 1);
         chk("idle_serial_out", bus.serial_out, 0);
         chk("idle_done", bus.done, 0);
      end else begin
         item_t it;
         it = q.pop_front();
         chk("busy", bus.busy, 1);
         chk("done", bus.done, it.last);
         chk("in_ready", bus.in_ready, it.last);
         chk("serial_out", bus.serial_out, it.b);
         if (it.par) begin
            chk("par_valid", bus.par_valid, 1);
            chk("par_shift_en", bus.shift_en, 0);
         end else begin
            chk("shift_en", bus.shift_en, 1);
            chk("data_par_valid", bus.par_valid, 0);
            rx_m = it.ord ? {rx_m[W-2:0], bus.serial_out} : {bus.serial_out, rx_m[W-1:1]};
            if (it.chk) chk("rx_word", rx_m, it.rx);
         end
      end
   endtask

   // Called just after a falling edge: note whether the coming rising edge accepts.
   task automatic cycle();
      accepted = bus.in_valid && bus.in_ready;
      if (accepted) push_frame();
      @(posedge clk);
      @(negedge clk);
      monitor();
   endtask

   task automatic drive(input logic [W-1:0] d, input logic m, input logic [W-1:0] s, input logic [W-1:0] r);
      bus.din = d; bus.msb_first = m; bus.in_valid = 1'b1;
      pend_seq = s; pend_rx = r;
   endtask

   task automatic wait_accept(input string nm);
      int t = 0;
      accepted = 1'b0;
      while (!accepted && t < 20) begin cycle(); t++; end
      chk(nm, accepted, 1);
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() > 0 && t < 20) begin cycle(); t++; end
      chk("drain", q.size(), 0);
      cycle();
   endtask

   initial begin
      vecs[0] = '{din: 4'b1011, msb: 1'b0, seq: 4'b1011, rx: 4'b1011};
      vecs[1] = '{din: 4'b1011, msb: 1'b1, seq: 4'b1101, rx: 4'b1011};
      vecs[2] = '{din: 4'hA,    msb: 1'b0, seq: 4'b1010, rx: 4'hA};
      vecs[3] = '{din: 4'h5,    msb: 1'b1, seq: 4'b1010, rx: 4'h5};
      vecs[4] = '{din: 4'h3,    msb: 1'b1, seq: 4'b1100, rx: 4'h3};
      vecs[5] = '{din: 4'b0111, msb: 1'b0, seq: 4'b0111, rx: 4'b0111};

      bus.din = '0; bus.msb_first = 1'b0; bus.in_valid = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_shift_en", bus.shift_en, 0);
      chk("rst_serial_out", bus.serial_out, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_par_valid", bus.par_valid, 0);
      rst_n = 1'b1;
      cycle();

      foreach (vecs[v]) begin
         drive(vecs[v].din, vecs[v].msb, vecs[v].seq, vecs[v].rx);
         wait_accept("vec_accept");
         bus.in_valid = 1'b0;
         drain();
      end

      // Back-to-back with in_valid held across both words.
      max_run = 0; n_done = 0;
      drive(4'hA, 1'b0, 4'b1010, 4'hA);
      wait_accept("b2b_accept_a");
      drive(4'h5, 1'b0, 4'b0101, 4'h5);
      wait_accept("b2b_accept_b");
      bus.in_valid = 1'b0;
      drain();
      chk("b2b_run", max_run, 2 * FL);
      chk("b2b_done_count", n_done, 2);

      // New word offered mid-frame is taken only on the final-bit edge.
      drive(4'hA, 1'b0, 4'b1010, 4'hA);
      wait_accept("busy_accept_a");
      drive(4'hF, 1'b0, 4'b1111, 4'hF);
      cycle();
      chk("busy_ignore", accepted, 0);
      wait_accept("busy_accept_f");
      bus.in_valid = 1'b0;
      drain();

      // Asynchronous reset two bits into a frame.
      drive(4'h9, 1'b0, 4'b1001, 4'h9);
      wait_accept("rst_mid_accept");
      bus.in_valid = 1'b0;
      cycle();
      chk("rst_mid_busy_before", bus.busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rstm_in_ready", bus.in_ready, 1);
      chk("rstm_busy", bus.busy, 0);
      chk("rstm_shift_en", bus.shift_en, 0);
      chk("rstm_serial_out", bus.serial_out, 0);
      chk("rstm_done", bus.done, 0);
      chk("rstm_par_valid", bus.par_valid, 0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      drive(4'h3, 1'b0, 4'b0011, 4'h3);
      wait_accept("post_rst_accept");
      bus.in_valid = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
